// File: rtl/pfd_tdc_5bit.sv
// -----------------------------------------------------------------------------
// pfd_tdc_5bit
//   Counter-based phase/frequency detector and time-to-digital converter for
//   the ADPLL loop. The reference and DCO feedback clocks are synchronised
//   into the clk domain, and their rising edges are detected. The number of
//   clk cycles between a ref edge and the following fb edge (or fb then ref)
//   becomes a sign/magnitude error word. A lock flag is raised once enough
//   consecutive small errors have been seen.
//
//   Optional feature macro: PFD_DEADZONE_EN
//     When defined, results with magnitude <= DEADZONE are reported as 0/+.
//
// Ports
//   clk        in   system sampling clock
//   reset      in   synchronous, active-high reset
//   ref_in     in   reference clock (asynchronous to clk)
//   fb_in      in   feedback clock from the DCO
//   err_sign   out  1 = fb leads ref (DCO too fast), 0 = fb lags or equal
//   err_mag    out  |phase error| in clk cycles, saturated at 31
//   err_valid  out  one-cycle strobe marking a new err_sign/err_mag
//   lock       out  loop-locked indicator
// -----------------------------------------------------------------------------
module pfd_tdc_5bit #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64,
    parameter int LOCK_TOL    = 1,
    parameter int LOCK_CNT    = 8,
    parameter int DEADZONE    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ref_in,
    input  logic       fb_in,
    output logic       err_sign,
    output logic [4:0] err_mag,
    output logic       err_valid,
    output logic       lock
);

    localparam int               RUN_W      = $clog2(LOCK_CNT + 1);
    localparam logic [6:0]       TIMEOUT_C  = 7'(TIMEOUT);
    localparam logic [4:0]       LOCK_TOL_C = 5'(LOCK_TOL);
    localparam logic [RUN_W-1:0] LOCK_CNT_C = RUN_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEAS_REF = 2'd1,
        MEAS_FB  = 2'd2
    } state_t;

    // Synchronizers and edge detectors
    logic [SYNC_STAGES-1:0] ref_sync;
    logic [SYNC_STAGES-1:0] fb_sync;
    logic                   ref_prev;
    logic                   fb_prev;
    logic                   rise_r;
    logic                   rise_f;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours regardless of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            ref_sync <= '0;
            fb_sync  <= '0;
            ref_prev <= 1'b0;
            fb_prev  <= 1'b0;
        end else begin
            ref_sync <= {ref_sync[SYNC_STAGES-2:0], ref_in};
            fb_sync  <= {fb_sync[SYNC_STAGES-2:0], fb_in};
            ref_prev <= ref_sync[SYNC_STAGES-1];
            fb_prev  <= fb_sync[SYNC_STAGES-1];
        end
    end

    // Identical pipelines on both paths keep the relative edge timing intact.
    assign rise_r = ref_sync[SYNC_STAGES-1] & ~ref_prev;
    assign rise_f = fb_sync[SYNC_STAGES-1] & ~fb_prev;

    // Measurement FSM
    state_t     state;
    state_t     state_nxt;
    logic [6:0] count;
    logic [6:0] count_nxt;
    logic       res_valid;
    logic       res_sign;
    logic       res_timeout;
    logic [6:0] res_cnt;
    logic [4:0] res_mag;
    logic       out_sign;
    logic [4:0] out_mag;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value unassigned (no latches).
    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        res_valid   = 1'b0;
        res_sign    = 1'b0;
        res_timeout = 1'b0;
        res_cnt     = '0;
        case (state)
            IDLE: begin
                count_nxt = '0;
                if (rise_r && rise_f) begin
                    res_valid = 1'b1;
                end else if (rise_r) begin
                    state_nxt = MEAS_REF;
                    count_nxt = 7'd1;
                end else if (rise_f) begin
                    state_nxt = MEAS_FB;
                    count_nxt = 7'd1;
                end
            end
            MEAS_REF, MEAS_FB: begin
                res_sign = (state == MEAS_FB);
                // The closing edge wins; a coincident opposite edge is
                // absorbed because the FSM returns to IDLE unconditionally.
                if ((state == MEAS_REF) ? rise_f : rise_r) begin
                    res_valid = 1'b1;
                    res_cnt   = count;
                    state_nxt = IDLE;
                    count_nxt = '0;
                end else if (count >= TIMEOUT_C) begin
                    res_valid   = 1'b1;
                    res_timeout = 1'b1;
                    state_nxt   = IDLE;
                    count_nxt   = '0;
                end else begin
                    count_nxt = count + 7'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    assign res_mag = (res_timeout || res_cnt > 7'd31) ? 5'd31 : res_cnt[4:0];

`ifdef PFD_DEADZONE_EN
    localparam logic [4:0] DEADZONE_C = 5'(DEADZONE);
    // Small errors collapse to zero to stop the DCO dithering around lock.
    assign out_sign = (res_mag <= DEADZONE_C) ? 1'b0 : res_sign;
    assign out_mag  = (res_mag <= DEADZONE_C) ? 5'd0 : res_mag;
`else
    assign out_sign = res_sign;
    assign out_mag  = res_mag;
`endif

    // Lock tracking uses the magnitude actually reported.
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_inc;
    logic             qualify;

    assign qualify = ~res_timeout & (out_mag <= LOCK_TOL_C);
    assign run_inc = (run == LOCK_CNT_C) ? run : run + RUN_W'(1);

    // Result register: the lock flag updates alongside the result word.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_sign  <= 1'b0;
            err_mag   <= '0;
            err_valid <= 1'b0;
            lock      <= 1'b0;
            run       <= '0;
        end else begin
            err_valid <= res_valid;
            if (res_valid) begin
                err_sign <= out_sign;
                err_mag  <= out_mag;
                if (qualify) begin
                    run  <= run_inc;
                    lock <= (run_inc == LOCK_CNT_C);
                end else begin
                    run  <= '0;
                    lock <= 1'b0;
                end
            end
        end
    end

endmodule
